// File: rtl/simon_pkg.sv
//------------------------------------------------------------------------------
// Module : simon_pkg
// Brief  : Simon32/64 constants, types and the round function f().
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package simon_pkg;

    localparam int          SIMON_WORD   = 16;
    localparam int          SIMON_ROUNDS = 32;
    localparam logic [15:0] SIMON_C      = 16'hfffc;
    localparam logic [61:0] SIMON_Z0     = 62'h19C3522FB386A45F;

    typedef logic [SIMON_WORD-1:0] simon_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } simon_sched_st_e;

    // f(x) = (x<<<1 & x<<<8) ^ (x<<<2)
    function automatic simon_word_t simon_f(simon_word_t x);
        return ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/simon_enc_sched_if.sv
//------------------------------------------------------------------------------
// Module : simon_enc_sched_if
// Brief  : Block in/out valid/ready bundle; in_dec exists with SIMON_DECRYPT_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface simon_enc_sched_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_blk;
`ifdef SIMON_DECRYPT_EN
    logic        in_dec;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_blk;

    modport master (
`ifdef SIMON_DECRYPT_EN
        output in_dec,
`endif
        output in_valid,
        output in_blk,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_blk
    );

    modport slave (
`ifdef SIMON_DECRYPT_EN
        input  in_dec,
`endif
        input  in_valid,
        input  in_blk,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_blk
    );
endinterface

`default_nettype wire

// File: rtl/simon_round.sv
//------------------------------------------------------------------------------
// Module : simon_round
// Brief  : One combinational Simon32 round; inverse round with SIMON_DECRYPT_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module simon_round
    import simon_pkg::*;
(
    input  wire simon_word_t x,
    input  wire simon_word_t y,
    input  wire simon_word_t k,
`ifdef SIMON_DECRYPT_EN
    input  wire logic        dec,
`endif
    output simon_word_t      x_nxt,
    output simon_word_t      y_nxt
);

    always_comb begin
        x_nxt = y ^ simon_f(x) ^ k;
        y_nxt = x;
`ifdef SIMON_DECRYPT_EN
        if (dec) begin
            x_nxt = y;
            y_nxt = x ^ simon_f(y) ^ k;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/simon_enc_sched.sv
//------------------------------------------------------------------------------
// Module : simon_enc_sched
// Brief  : Simon32/64 sequencer: drives external key expansion, runs 32 rounds
//          per block, one per cycle. SIMON_DECRYPT_EN adds per-block decrypt.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module simon_enc_sched
    import simon_pkg::*;
#(
    parameter int KX_LAT = 30,
    parameter int ROUNDS = SIMON_ROUNDS
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic [63:0]               key_in,
    input  wire logic                      key_load,
    simon_enc_sched_if.slave               bus,
    output logic                           busy,
    output logic                           key_ok,
    output logic                           kx_start,
    output logic [63:0]                    kx_keytext,
    input  wire simon_word_t [ROUNDS-1:0]  kx_key
);

    localparam int              CW         = (KX_LAT > 1) ? $clog2(KX_LAT) : 1;
    localparam logic [CW-1:0]   c_kx_last  = CW'(KX_LAT - 1);
    localparam logic [4:0]      c_rnd_last = 5'(ROUNDS - 1);

    simon_sched_st_e r_state;
    simon_sched_st_e w_state_nxt;

    logic          r_key_ok;
    logic          r_kx_start;
    logic [63:0]   r_kx_keytext;
    logic [CW-1:0] r_cnt;
    simon_word_t   r_x;
    simon_word_t   r_y;
    logic [4:0]    r_rnd;
    logic [31:0]   r_out_blk;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_busy;
    logic          w_accept;
    logic          w_kx_done;
    logic          w_rnd_last;
    logic [4:0]    w_rnd_step;
    logic [4:0]    w_rnd_start;
    simon_word_t   w_x_nxt;
    simon_word_t   w_y_nxt;

    assign w_kx_done = (r_cnt == c_kx_last);
    assign w_accept  = bus.in_valid && w_in_ready;

`ifdef SIMON_DECRYPT_EN
    logic r_dec;

    assign w_rnd_last  = r_dec ? (r_rnd == 5'd0) : (r_rnd == c_rnd_last);
    assign w_rnd_step  = r_dec ? (r_rnd - 5'd1) : (r_rnd + 5'd1);
    assign w_rnd_start = bus.in_dec ? c_rnd_last : 5'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dec <= 1'b0;
        end else if (w_accept) begin
            r_dec <= bus.in_dec;
        end
    end
`else
    assign w_rnd_last  = (r_rnd == c_rnd_last);
    assign w_rnd_step  = r_rnd + 5'd1;
    assign w_rnd_start = 5'd0;
`endif

    simon_round u_round (
        .x     (r_x),
        .y     (r_y),
        .k     (kx_key[r_rnd]),
`ifdef SIMON_DECRYPT_EN
        .dec   (r_dec),
`endif
        .x_nxt (w_x_nxt),
        .y_nxt (w_y_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready is masked by key_load so a colliding block never sees a handshake
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy     = 1'b0;
                w_in_ready = r_key_ok && !key_load;
                if (key_load) begin
                    w_state_nxt = KEXP;
                end else if (bus.in_valid && w_in_ready) begin
                    w_state_nxt = RUN;
                end
            end
            KEXP: begin
                if (w_kx_done) begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_rnd_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_ok     <= 1'b0;
            r_kx_start   <= 1'b0;
            r_kx_keytext <= 64'd0;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_rnd        <= 5'd0;
            r_out_blk    <= 32'd0;
        end else begin
            r_kx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (key_load) begin
                        r_kx_keytext <= {key_in[15:0], key_in[31:16], key_in[47:32], key_in[63:48]};
                        r_key_ok     <= 1'b0;
                        r_kx_start   <= 1'b1;
                        r_cnt        <= '0;
                    end else if (w_accept) begin
                        r_x   <= bus.in_blk[31:16];
                        r_y   <= bus.in_blk[15:0];
                        r_rnd <= w_rnd_start;
                    end
                end
                KEXP: begin
                    if (w_kx_done) begin
                        r_key_ok <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                    if (w_rnd_last) begin
                        r_rnd     <= 5'd0;
                        r_out_blk <= {w_x_nxt, w_y_nxt};
                    end else begin
                        r_rnd <= w_rnd_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_blk   = r_out_blk;
    assign busy          = w_busy;
    assign key_ok        = r_key_ok;
    assign kx_start      = r_kx_start;
    assign kx_keytext    = r_kx_keytext;

endmodule

`default_nettype wire
